// File: rtl/activation_unit_pkg.sv
// Shared types and default parameters for the activation unit.
// Leaky mode is compiled in only with ACTIVATION_LEAKY_EN defined.
package activation_unit_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_CLAMP  = 2'b10,
    ACT_LEAKY  = 2'b11
  } act_mode_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/activation_unit_if.sv
// Beat handshake bundle between a producer/consumer and the activation unit.
interface activation_unit_if
  import activation_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH
);
  logic                               in_valid;
  logic                               in_ready;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  in_data;
  act_mode_t                          mode;
  logic [DATA_WIDTH-1:0]              clamp_max;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  out_data;

  modport master (
    output in_valid, in_data, mode, clamp_max, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, mode, clamp_max, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/activation_unit_act_lane.sv
// Per-lane combinational activation and clip flag.
// Leaky ReLU exists only with ACTIVATION_LEAKY_EN; otherwise mode 11 acts as ReLU.
module act_lane
  import activation_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  act_mode_t                    mode,
  input  logic signed [DATA_WIDTH-1:0] clamp_max,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         clip
);

  if (LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_shift
    $error("act_lane: LEAK_SHIFT out of range");
  end

  logic                         nonpos;
  logic signed [DATA_WIDTH-1:0] bound;

  always_comb begin
    nonpos = x[DATA_WIDTH-1] || (x == '0);
    // a negative ceiling collapses the clamp window to zero
    bound  = clamp_max[DATA_WIDTH-1] ? '0 : clamp_max;
    y      = x;
    clip   = 1'b0;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_CLAMP: begin
        if (nonpos) y = '0;
        else if (x > bound) begin
          y    = bound;
          clip = 1'b1;
        end
      end
`ifdef ACTIVATION_LEAKY_EN
      ACT_LEAKY: y = x[DATA_WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
`endif
      default: y = nonpos ? '0 : x;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Two-stage elastic activation pipeline with a saturating clip counter.
// Mode 11 leaky behaviour depends on ACTIVATION_LEAKY_EN (see act_lane).
module activation_unit
  import activation_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  activation_unit_if.slave     bus,
  input  logic                 clip_cnt_clr,
  output logic [CNT_WIDTH-1:0] clip_cnt
);

  typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] beat_t;

  logic [2:1]            vld_pipe;
  beat_t                 s1_data, s2_data, res;
  act_mode_t             s1_mode;
  logic [DATA_WIDTH-1:0] s1_cmax;
  logic [NUM_CH-1:0]     clip_lane;
  logic                  s2_clip;
  logic                  s1_advance;

  // stage 1 may hand off when stage 2 is empty or draining this cycle
  assign s1_advance    = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready  = !vld_pipe[1] || s1_advance;
  assign bus.out_valid = vld_pipe[2];
  assign bus.out_data  = s2_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    act_lane #(.DATA_WIDTH(DATA_WIDTH), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .x         (s1_data[g]),
      .mode      (s1_mode),
      .clamp_max (s1_cmax),
      .y         (res[g]),
      .clip      (clip_lane[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_data     <= '0;
      s1_mode     <= ACT_BYPASS;
      s1_cmax     <= '0;
    end else if (bus.in_ready) begin
      vld_pipe[1] <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= bus.in_data;
        s1_mode <= bus.mode;
        s1_cmax <= bus.clamp_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      s2_data     <= '0;
      s2_clip     <= 1'b0;
    end else if (s1_advance) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        s2_data <= res;
        s2_clip <= |clip_lane;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip_cnt <= '0;
    else if (clip_cnt_clr)
      clip_cnt <= '0;
    else if (vld_pipe[2] && bus.out_ready && s2_clip && !(&clip_cnt))
      clip_cnt <= clip_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit (4-bit clip counter instance).
module tb_activation_unit;
  import activation_unit_pkg::*;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clip_cnt_clr;
  logic [CW-1:0] clip_cnt;
  int            total = 0;
  int            bad   = 0;

  activation_unit_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

  activation_unit #(.DATA_WIDTH(DW), .NUM_CH(NC), .LEAK_SHIFT(3), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clip_cnt_clr (clip_cnt_clr),
    .clip_cnt     (clip_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [31:0] beat(input int k);
    return pk(k, -k, k + 10, 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one beat through an idle pipe with out_ready high
  task automatic send1(input string tag, input act_mode_t m, input int cmax,
                       input logic [31:0] din, input logic [31:0] exp);
    bus.mode      = m;
    bus.clamp_max = cmax[7:0];
    bus.in_data   = din;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 0);
    step();
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_data"}, bus.out_data, exp);
    step();
  endtask

  initial begin
    logic [31:0] prev_data;
    bit          prev_stall;
    bit          saw_full;
    bit          do_in, do_out;
    int          sent, rcvd;

    rst_n         = 1'b0;
    clip_cnt_clr  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = ACT_BYPASS;
    bus.clamp_max = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_clip_cnt", 32'(clip_cnt), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    bus.out_ready = 1'b1;
    send1("relu", ACT_RELU, 0, pk(-5, 0, 7, 127), pk(0, 0, 7, 127));
    chk("relu_drained", 32'(bus.out_valid), 0);

    send1("clamp6", ACT_CLAMP, 6, pk(10, 6, -3, 2), pk(6, 6, 0, 2));
    chk("clamp6_cnt", 32'(clip_cnt), 1);
    send1("clampneg", ACT_CLAMP, -4, pk(5, -2, 0, 1), pk(0, 0, 0, 0));
    chk("clampneg_cnt", 32'(clip_cnt), 2);

`ifdef ACTIVATION_LEAKY_EN
    send1("leaky", ACT_LEAKY, 0, pk(-16, -1, -128, 9), pk(-2, -1, -16, 9));
`else
    send1("leaky", ACT_LEAKY, 0, pk(-16, -1, -128, 9), pk(0, 0, 0, 9));
`endif
    chk("leaky_cnt", 32'(clip_cnt), 2);
    send1("bypass", ACT_BYPASS, 0, pk(-128, 127, -1, 3), pk(-128, 127, -1, 3));

    // saturate the counter, then clear alongside a clipped delivery
    clip_cnt_clr = 1'b1;
    step();
    clip_cnt_clr = 1'b0;
    chk("clr_cnt", 32'(clip_cnt), 0);
    bus.mode      = ACT_CLAMP;
    bus.clamp_max = '0;
    bus.in_data   = pk(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("cnt_full", 32'(clip_cnt), 15);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("cnt_sat", 32'(clip_cnt), 15);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("clr_prio_valid", 32'(bus.out_valid), 1);
    clip_cnt_clr = 1'b1;
    step();
    clip_cnt_clr = 1'b0;
    chk("clr_prio", 32'(clip_cnt), 0);
    step();
    chk("clr_prio_hold", 32'(clip_cnt), 0);

    // back-pressured stream of 8 bypass beats
    bus.mode   = ACT_BYPASS;
    sent       = 0;
    rcvd       = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    saw_full   = 1'b0;
    for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
      bus.out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < 8);
      bus.in_data   = beat(sent);
      #1;
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && !bus.out_ready && (sent - rcvd) == 2) begin
        chk("full_in_ready", 32'(bus.in_ready), 0);
        saw_full = 1'b1;
      end
      do_in  = bus.in_valid && bus.in_ready;
      do_out = bus.out_valid && bus.out_ready;
      if (do_out) begin
        chk("stream_order", bus.out_data, beat(rcvd));
        rcvd++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (do_in) sent++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("stream_count", rcvd, 8);
    chk("stream_saw_full", 32'(saw_full), 1);

    // reset with two beats in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = beat(20);
    step();
    bus.in_data   = beat(21);
    step();
    bus.in_valid  = 1'b0;
    chk("flight_valid", 32'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 0);
    chk("async_rst_data", bus.out_data, 0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_stale", 32'(bus.out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, signed lane width in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 4, lanes processed per beat.
REQ-003 The block SHALL have parameter LEAK_SHIFT, default 3, arithmetic right-shift amount for leaky mode.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, clip counter width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 mode  input  2  00 bypass, 01 ReLU, 10 clamped ReLU, 11 leaky ReLU.
REQ-009 clamp_max  input  DATA_WIDTH  signed upper bound for mode 10.
REQ-010 in_valid / in_ready  input / output  1 each  upstream handshake.
REQ-011 in_data  input  NUM_CH*DATA_WIDTH  packed signed lanes, lane 0 in LSBs.
REQ-012 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-013 out_data  output  NUM_CH*DATA_WIDTH  packed signed results.
REQ-014 clip_cnt_clr  input  1  synchronous clear of clip_cnt.
REQ-015 clip_cnt  output  CNT_WIDTH  count of delivered beats with at least one clamped lane.

Function
REQ-016 Transfer SHALL occur on a rising edge where valid and ready are both high; mode and clamp_max SHALL be sampled with the beat on input transfer.
REQ-017 The datapath SHALL be a 2-stage register pipeline: stage 1 captures data and mode; stage 2 holds the registered result; latency 2 cycles from input transfer to out_valid with out_ready high.
REQ-018 Throughput SHALL be one beat per cycle; each stage advances when empty or downstream ready; in_ready = !s1_valid || s1_advance (combinational from out_ready).
REQ-019 Under back-pressure, out_data and out_valid SHALL hold stable until transfer; no beat SHALL be dropped or duplicated.
REQ-020 Bypass: y = x. ReLU: y = 0 if x <= 0, else x.
REQ-021 Clamped ReLU: negative clamp_max SHALL be treated as 0; y = 0 if x <= 0, y = clamp_max if x > clamp_max, else x; a lane hitting the upper bound is "clipped".
REQ-022 Leaky: y = x if x >= 0, else x >>> LEAK_SHIFT (arithmetic, rounds toward minus infinity; -1 stays -1).
REQ-023 Lanes SHALL be independent; no output width growth.
REQ-024 clip_cnt SHALL increment by 1 on each output transfer whose beat had any clipped lane, saturating at all-ones; clip_cnt_clr SHALL take priority over a same-cycle increment.

Reset
REQ-025 On rst_n low, all valid flags and clip_cnt SHALL clear to 0 immediately; out_data SHALL reset to 0; in_ready SHALL be 1 after reset release.
REQ-026 Beats in flight at reset assertion SHALL be discarded.

Configuration
REQ-027 Macro ACTIVATION_LEAKY_EN: when defined, mode 11 performs leaky ReLU; when undefined, leaky logic SHALL be absent and mode 11 SHALL behave as mode 01.

Structure
REQ-028 A shared package SHALL hold the mode enum (ACT_BYPASS, ACT_RELU, ACT_CLAMP, ACT_LEAKY) and default parameter constants.
REQ-029 One sub-module act_lane SHALL implement the per-lane combinational function and clip flag, instantiated NUM_CH times.

Verification
REQ-030 Mode 01, lanes {-5,0,7,127}, out_ready high -> out {0,0,7,127} exactly 2 cycles after transfer.
REQ-031 Mode 10, clamp_max=6, lanes {10,6,-3,2} -> {6,6,0,2}, clip_cnt 0->1; clamp_max=-4, lane 5 -> 0.
REQ-032 Mode 11 with macro defined, LEAK_SHIFT=3, lanes {-16,-1,-128,9} -> {-2,-1,-16,9}; without macro -> {0,0,0,9}.
REQ-033 Stream 8 beats, out_ready toggled randomly -> all 8 delivered in order, out_data stable while stalled, in_ready low when both stages full and out_ready low.
REQ-034 clip_cnt at all-ones plus clipped beat -> stays all-ones; clip_cnt_clr with clipped beat same cycle -> 0.
REQ-035 rst_n asserted with 2 beats in flight -> out_valid 0 asynchronously, no stale beat after release.
